// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a little-endian byte stream into imem words and holds the core in reset until loaded
module imem_boot_loader #(
  parameter int PROG_SIZE      = 7,
  parameter int ADDR_W         = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {RECV, WRITE, DONE, ERR} state_t;
  state_t        state_q;
  logic [1:0]    byte_cnt_q;
  logic [TW-1:0] timer_q;
  logic          accept;
  assign accept = byte_valid && byte_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RECV;
      byte_ready   <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_rst     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      byte_cnt_q   <= '0;
      timer_q      <= '0;
    end else begin
      case (state_q)
        RECV: begin
          if (accept) begin
            imem_wdata[8*byte_cnt_q +: 8] <= byte_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            timer_q    <= '0;
            if (byte_cnt_q == 2'd3) begin
              state_q    <= WRITE;
              imem_we    <= 1'b1;
              byte_ready <= 1'b0;
            end
          end else if (byte_cnt_q != 2'd0) begin
            // stall inside a partial word; give up after the idle budget
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
              state_q    <= ERR;
              err        <= 1'b1;
              byte_ready <= 1'b0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end
        WRITE: begin
          imem_we      <= 1'b0;
          words_loaded <= words_loaded + 1'b1;
          byte_cnt_q   <= '0;
          if (imem_addr == ADDR_W'(PROG_SIZE)) begin
            state_q  <= DONE;
            core_rst <= 1'b0;
            done     <= 1'b1;
          end else begin
            imem_addr  <= imem_addr + 1'b1;
            state_q    <= RECV;
            byte_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench; expected words are queued as issued and popped on each imem write pulse
module tb_imem_boot_loader;
  localparam int PS = 7, AW = 3, TO = 1000;
  logic clk = 0, rst = 1, byte_valid = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, imem_we, core_rst, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] words_loaded;
  int checks = 0, errors = 0, pulses = 0;
  bit mon_en = 0;
  logic [AW+31:0] sb[$];
  logic [AW+31:0] exp_w;

  imem_boot_loader #(.PROG_SIZE(PS), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("ready_rule", byte_ready, !(imem_we || done || err));
    if (imem_we) begin
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", imem_addr, imem_wdata);
      end else begin
        exp_w = sb.pop_front();
        chk("imem_addr", imem_addr, exp_w[AW+31:32]);
        chk("imem_wdata", imem_wdata, exp_w[31:0]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n = 0;
    ok = 0;
    byte_valid = 1;
    byte_data = b;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk);
      #1;
      n++;
    end
    byte_valid = 0;
  endtask

  task automatic load(input int nw, input int gap);
    bit ok;
    logic [31:0] d;
    for (int w = 0; w < nw; w++) begin
      d = (w == 0) ? 32'h00100093 : $urandom;
      sb.push_back({AW'(w), d});
      for (int b = 0; b < 4; b++) begin
        if (gap > 0) idle($urandom_range(0, gap));
        send_byte(d[8*b +: 8], ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL byte_accept: word %0d byte %0d got not-accepted expected accepted", w, b);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1;
    byte_valid = 0;
    @(posedge clk);
    #1;
    rst = 0;
    chk("rst_ready", byte_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_words", words_loaded, 0);
  endtask

  task automatic check_loaded(input int np);
    chk("done", done, 1);
    chk("core_rst_released", core_rst, 0);
    chk("words_loaded", words_loaded, PS + 1);
    chk("pulse_count", pulses, np);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    bit ok;
    do_reset();
    mon_en = 1;
    load(PS + 1, 0);
    chk("done_before_final", done, 0);
    chk("core_rst_before_final", core_rst, 1);
    idle(1);
    check_loaded(PS + 1);
    byte_valid = 1;
    for (int i = 0; i < 8; i++) begin
      byte_data = 8'($urandom);
      @(negedge clk);
      chk("ready_after_done", byte_ready, 0);
      @(posedge clk);
      #1;
    end
    byte_valid = 0;
    check_loaded(PS + 1);

    do_reset();
    pulses = 0;
    load(PS + 1, 20);
    idle(1);
    check_loaded(PS + 1);

    do_reset();
    pulses = 0;
    load(3, 2);
    idle(2);
    chk("partial_words", words_loaded, 3);
    chk("partial_addr", imem_addr, 3);
    chk("partial_core_rst", core_rst, 1);
    do_reset();
    load(PS + 1, 3);
    idle(1);
    check_loaded(PS + 4);

    do_reset();
    pulses = 0;
    send_byte(8'h11, ok);
    chk("to_byte0", ok, 1);
    send_byte(8'h22, ok);
    chk("to_byte1", ok, 1);
    idle(TO - 1);
    chk("err_not_yet", err, 0);
    idle(1);
    chk("err_set", err, 1);
    chk("err_core_rst", core_rst, 1);
    chk("err_ready", byte_ready, 0);
    byte_valid = 1;
    byte_data = 8'h33;
    idle(10);
    byte_valid = 0;
    chk("err_sticky", err, 1);
    chk("err_no_write", pulses, 0);
    chk("err_words", words_loaded, 0);
    chk("err_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
